// File: rtl/impl_sched_pkg.sv
// impl_sched_pkg: FSM encoding, requester IDs and stats width shared by impl_sched.
package impl_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0   = 1'b0;
    localparam logic REQ1   = 1'b1;
    localparam int   STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/impl_sched_unit.sv
// impl_sched_unit: shared adder, single-cycle (fast_impl) or bit-serial over WIDTH cycles (slow_impl).
// done is high in the cycle whose closing edge makes sum final.
module impl_sched_unit #(
    parameter bit USE_FAST = 1'b1,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] sum
);

    generate
        if (USE_FAST) begin : fast_impl
            always_ff @(posedge clk) begin
                if (rst)
                    sum <= '0;
                else if (start)
                    sum <= a + b;
            end
            assign done = start;
        end else begin : slow_impl
            localparam int CW = $clog2(WIDTH);
            logic [CW-1:0]    cnt;
            logic [WIDTH-1:0] a_sh, b_sh;
            logic             carry, run;
            // bit 0 is resolved on the start edge so the result is final WIDTH cycles after start
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt   <= '0;
                    a_sh  <= '0;
                    b_sh  <= '0;
                    carry <= 1'b0;
                    run   <= 1'b0;
                    sum   <= '0;
                end else if (start) begin
                    a_sh  <= a >> 1;
                    b_sh  <= b >> 1;
                    sum   <= {a[0] ^ b[0], sum[WIDTH-1:1]};
                    carry <= a[0] & b[0];
                    cnt   <= CW'(1);
                    run   <= 1'b1;
                end else if (run) begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {a_sh[0] ^ b_sh[0] ^ carry, sum[WIDTH-1:1]};
                    carry <= (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
                    cnt   <= cnt + 1'b1;
                    run   <= cnt != CW'(WIDTH - 1);
                end
            end
            assign done = run && (cnt == CW'(WIDTH - 1));
        end
    endgenerate

endmodule

// File: rtl/impl_sched.sv
// impl_sched: round-robin scheduler sharing one adder between two requesters.
// Optional IMPL_SCHED_STATS_EN enables the saturating ops/stall counters.
module impl_sched
    import impl_sched_pkg::*;
#(
    parameter bit USE_FAST = 1'b1,
    parameter int WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              busy,
    output logic [STAT_W-1:0] stat_ops0,
    output logic [STAT_W-1:0] stat_ops1,
    output logic [STAT_W-1:0] stat_stall
);

    state_t           state;
    logic             last_grant, gnt1, accept, done;
    logic [WIDTH-1:0] sum;

    // on a tie the requester that did not win last time gets the grant
    assign gnt1       = req1_valid && (!req0_valid || last_grant == REQ0);
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt1;
    assign req1_ready = accept && gnt1;
    assign rsp_data   = sum;

    impl_sched_unit #(.USE_FAST(USE_FAST), .WIDTH(WIDTH)) u_unit (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .a     (gnt1 ? req1_a : req0_a),
        .b     (gnt1 ? req1_b : req0_b),
        .done  (done),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ1;
            rsp_valid  <= 1'b0;
            rsp_id     <= REQ0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rsp_id     <= gnt1 ? REQ1 : REQ0;
                    last_grant <= gnt1 ? REQ1 : REQ0;
                    busy       <= 1'b1;
                    rsp_valid  <= done;
                    state      <= done ? DONE : EXEC;
                end
                EXEC: if (done) begin
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMPL_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops0  <= '0;
            stat_ops1  <= '0;
            stat_stall <= '0;
        end else begin
            if (req0_ready)
                stat_ops0 <= sat_inc(stat_ops0);
            if (req1_ready)
                stat_ops1 <= sat_inc(stat_ops1);
            if (rsp_valid && !rsp_ready)
                stat_stall <= sat_inc(stat_stall);
        end
    end
`else
    assign stat_ops0  = '0;
    assign stat_ops1  = '0;
    assign stat_stall = '0;
`endif

endmodule
